// File: rtl/max6675_responder.sv
// SPI responder emulating a MAX6675 thermocouple converter, including its conversion timing.
// Define MAX6675_OPEN_DETECT_EN to report the latched tc_open flag in frame bit 2.
module max6675_responder #(
    parameter int CONV_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [11:0] temp_in,
    input  logic        tc_open,
    output logic        frame_done,
    output logic        conv_valid
);

    localparam int CNT_W = (CONV_CYCLES < 2) ? 1 : $clog2(CONV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CONV_RELOAD = CNT_W'(CONV_CYCLES);
    localparam logic [4:0] FRAME_BITS = 5'd16;
`ifdef MAX6675_OPEN_DETECT_EN
    localparam logic OPEN_EN = 1'b1;
`else
    localparam logic OPEN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic [15:0] build_frame(input logic [11:0] temp, input logic open_bit);
        return {1'b0, temp, open_bit, 1'b0, 1'b0};
    endfunction

    // Synchroniser chain: _p0/_p1 are the two metastability flops, _p2 is the edge history.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;

    state_t           state, state_nxt;
    logic [15:0]      shift_reg, shift_nxt;
    logic [4:0]       bit_cnt, bit_cnt_nxt;
    logic             miso_nxt, oe_nxt, done_nxt;
    logic [CNT_W-1:0] conv_cnt, conv_cnt_nxt;
    logic             conv_run, conv_run_nxt;
    logic [11:0]      conv_reg, conv_reg_nxt;
    logic             open_reg, open_reg_nxt;
    logic             conv_valid_nxt;

    logic sclk_fall, cs_fall, cs_rise;

    assign sclk_fall = sclk_p2 & ~sclk_p1;
    assign cs_fall   = cs_p2 & ~cs_p1;
    assign cs_rise   = ~cs_p2 & cs_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
        end else begin
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi_cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARM;
            bit_cnt     <= 5'd0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_done  <= 1'b0;
            conv_cnt    <= CONV_RELOAD;
            conv_run    <= 1'b1;
            conv_reg    <= 12'd0;
            open_reg    <= 1'b0;
            conv_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            spi_miso    <= miso_nxt;
            spi_miso_oe <= oe_nxt;
            frame_done  <= done_nxt;
            conv_cnt    <= conv_cnt_nxt;
            conv_run    <= conv_run_nxt;
            conv_reg    <= conv_reg_nxt;
            open_reg    <= open_reg_nxt;
            conv_valid  <= conv_valid_nxt;
        end
    end

    // Frame data is only consumed after a CS-fall load, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_reg <= shift_nxt;
    end

    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift_reg;
        bit_cnt_nxt    = bit_cnt;
        miso_nxt       = spi_miso;
        oe_nxt         = spi_miso_oe;
        done_nxt       = 1'b0;
        conv_cnt_nxt   = conv_cnt;
        conv_run_nxt   = conv_run;
        conv_reg_nxt   = conv_reg;
        open_reg_nxt   = open_reg;
        conv_valid_nxt = conv_valid;

        case (state)
            ARM: begin
                if (cs_p1) begin
                    state_nxt = IDLE;
                end
                if (cs_rise) begin
                    conv_cnt_nxt = CONV_RELOAD;
                    conv_run_nxt = 1'b1;
                end
            end

            IDLE: begin
                if (cs_fall) begin
                    shift_nxt    = build_frame(conv_reg, open_reg & OPEN_EN);
                    miso_nxt     = conv_reg[11] & 1'b0;
                    oe_nxt       = 1'b1;
                    bit_cnt_nxt  = 5'd0;
                    conv_run_nxt = 1'b0;
                    state_nxt    = SHIFT;
                end else if (conv_run) begin
                    // The count sits at zero for one cycle before the result is taken.
                    if (conv_cnt == '0) begin
                        conv_reg_nxt   = temp_in;
                        open_reg_nxt   = tc_open;
                        conv_valid_nxt = 1'b1;
                        conv_run_nxt   = 1'b0;
                    end else begin
                        conv_cnt_nxt = conv_cnt - CNT_W'(1);
                    end
                end
            end

            SHIFT: begin
                // A CS rise in the same cycle as an SCLK fall takes priority.
                if (cs_rise) begin
                    oe_nxt       = 1'b0;
                    miso_nxt     = 1'b0;
                    state_nxt    = IDLE;
                    conv_cnt_nxt = CONV_RELOAD;
                    conv_run_nxt = 1'b1;
                end else if (sclk_fall && (bit_cnt < FRAME_BITS)) begin
                    shift_nxt   = {shift_reg[14:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == FRAME_BITS - 5'd1) begin
                        miso_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        miso_nxt = shift_reg[14];
                    end
                end
            end

            default: begin
                state_nxt = ARM;
            end
        endcase
    end

endmodule

// File: tb/tb_max6675_responder.sv
// Scoreboard bench for max6675_responder: a master drives SPI frames, a monitor compares on frame_done.
module tb_max6675_responder;

    localparam int CONV = 1000;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [11:0] temp_in = 12'd0;
    logic        tc_open = 1'b0;
    logic        frame_done;
    logic        conv_valid;

    int n_cmp = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_sh = 16'd0;

    max6675_responder #(.CONV_CYCLES(CONV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi_sclk(spi_sclk),
        .spi_cs(spi_cs),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .temp_in(temp_in),
        .tc_open(tc_open),
        .frame_done(frame_done),
        .conv_valid(conv_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: collect MISO on every master rising edge; compare a full frame on frame_done.
    always @(posedge spi_sclk) begin
        if (!spi_cs) mon_sh = {mon_sh[14:0], spi_miso};
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL frame_unexpected: got %h, expected no frame", mon_sh);
            end else begin
                check("frame", {16'd0, mon_sh}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Master transaction: nclk SCLK pulses; a full frame queues its expected word.
    task automatic spi_frame(input int nclk, input logic [15:0] exp, input int chg_bit,
                             input logic [11:0] chg_val, output logic [31:0] rx);
        int fd0;
        fd0 = fd_cnt;
        rx = 32'd0;
        if (nclk >= 16) exp_q.push_back(exp);
        spi_cs = 1'b0;
        clk_n(HALF);
        check("oe_during_frame", {31'd0, spi_miso_oe}, 32'd1);
        for (int i = 0; i < nclk; i++) begin
            spi_sclk = 1'b1;
            rx = {rx[30:0], spi_miso};
            if (i == chg_bit) temp_in = chg_val;
            clk_n(HALF);
            spi_sclk = 1'b0;
            clk_n(HALF);
        end
        spi_cs = 1'b1;
        clk_n(4);
        check("oe_after_cs_rise", {31'd0, spi_miso_oe}, 32'd0);
        check("miso_after_cs_rise", {31'd0, spi_miso}, 32'd0);
        clk_n(4);
        check("frame_done_count", fd_cnt - fd0, (nclk >= 16) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        logic [15:0] open_exp;

        clk_n(5);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_conv_valid", {31'd0, conv_valid}, 32'd0);
        rst_n = 1'b1;

        // Early read before the first conversion completes: previous result is zero.
        temp_in = 12'h064;
        clk_n(50);
        spi_frame(16, 16'h0000, -1, 12'h000, rx);
        check("conv_valid_early", {31'd0, conv_valid}, 32'd0);

        // Completed conversion of 12'h064.
        clk_n(CONV + 10);
        check("conv_valid_done", {31'd0, conv_valid}, 32'd1);
        spi_frame(16, 16'h0320, -1, 12'h000, rx);
        check("rx_0320", rx, 32'h0000_0320);

        // temp_in changes mid-frame must not disturb the frame in flight.
        temp_in = 12'hFFF;
        clk_n(CONV + 10);
        spi_frame(16, 16'h7FF8, 5, 12'h001, rx);
        clk_n(CONV + 10);
        spi_frame(16, 16'h0008, -1, 12'h000, rx);

        // Aborted frame after 7 falls, then an immediate full read.
        spi_frame(7, 16'h0000, -1, 12'h000, rx);
        check("rx_abort_bits", rx, 32'h0000_0000);
        spi_frame(16, 16'h0008, -1, 12'h000, rx);

        // 20 pulses: trailing bits are zero and frame_done fires once.
        spi_frame(20, 16'h0008, -1, 12'h000, rx);
        check("rx_20_trailing", {28'd0, rx[3:0]}, 32'd0);
        check("rx_20_frame", {16'd0, rx[19:4]}, 32'h0000_0008);

        // Open thermocouple flag.
`ifdef MAX6675_OPEN_DETECT_EN
        open_exp = 16'h0324;
`else
        open_exp = 16'h0320;
`endif
        temp_in = 12'h064;
        tc_open = 1'b1;
        clk_n(CONV + 10);
        spi_frame(16, open_exp, -1, 12'h000, rx);

        clk_n(10);
        check("scoreboard_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
